// File: rtl/sigmag_packer_if.sv
// Output word stream between the sign/magnitude packer and the bus/DMA sink.
// The master drives data/valid; the slave drives ready.
interface sigmag_packer_if #(
  parameter int unsigned WORD_W = 32
);
  logic [WORD_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport master (output m_data, output m_valid, input m_ready);
  modport slave  (input m_data, input m_valid, output m_ready);
endinterface

// File: rtl/sigmag_packer.sv
// Packs 2-bit {sig,mag} quantiser samples into words, queues them in a
// first-word-fall-through FIFO and counts words dropped while the FIFO is full.
module sigmag_packer #(
  parameter int unsigned WORD_W     = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          en,
  input  logic                          sig_i,
  input  logic                          mag_i,
  input  logic                          clear,
  sigmag_packer_if.master               m,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              ovf_cnt,
  output logic                          ovf_sticky
);

  localparam int unsigned NS    = WORD_W / 2;
  localparam int unsigned IDX_W = $clog2(NS);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PW    = AW + 1;

  logic [IDX_W-1:0]  r_idx;
  logic [WORD_W-1:0] r_shift;
  logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0]     r_wptr;
  logic [PW-1:0]     r_rptr;
  logic [CNT_W-1:0]  r_ovf_cnt;
  logic              r_ovf_sticky;

  logic [WORD_W-1:0] w_word;
  logic              w_last;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_accept;
  logic              w_drop;

  // Current sample merged into the partially assembled word.
  always_comb begin
    w_word = r_shift;
    w_word[{r_idx, 1'b0} +: 2] = {sig_i, mag_i};
  end

  assign w_last   = en && (r_idx == IDX_W'(NS - 1));
  assign w_empty  = (r_wptr == r_rptr);
  assign w_full   = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_pop    = !w_empty && m.m_ready;
  // A pop on the same edge frees the slot the push needs, so full does not drop.
  assign w_accept = w_last && (!w_full || w_pop);
  assign w_drop   = w_last && !w_accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx        <= '0;
      r_shift      <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_ovf_cnt    <= '0;
      r_ovf_sticky <= 1'b0;
    end else if (clear) begin
      r_idx        <= '0;
      r_shift      <= '0;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_ovf_cnt    <= '0;
      r_ovf_sticky <= 1'b0;
    end else begin
      if (en) begin
        if (w_last) begin
          r_idx   <= '0;
          r_shift <= '0;
        end else begin
          r_idx   <= r_idx + 1'b1;
          r_shift <= w_word;
        end
      end
      if (w_accept) r_wptr <= r_wptr + 1'b1;
      if (w_pop)    r_rptr <= r_rptr + 1'b1;
      if (w_drop) begin
        r_ovf_sticky <= 1'b1;
        if (r_ovf_cnt != '1) r_ovf_cnt <= r_ovf_cnt + 1'b1;
      end
    end
  end

  // Storage needs no reset: the read port is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!reset && !clear && w_accept) r_mem[r_wptr[AW-1:0]] <= w_word;
  end

  assign m.m_valid  = !w_empty;
  assign m.m_data   = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign fifo_level = r_wptr - r_rptr;
  assign ovf_cnt    = r_ovf_cnt;
  assign ovf_sticky = r_ovf_sticky;

endmodule

// File: tb/tb_sigmag_packer.sv
// Directed bench for sigmag_packer (WORD_W=8, FIFO_DEPTH=4, CNT_W=4) with a
// scoreboard queue filled by stimulus and drained by an independent monitor.
module tb_sigmag_packer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       sig_i = 1'b0;
  logic       mag_i = 1'b0;
  logic       clear = 1'b0;
  logic [2:0] fifo_level;
  logic [3:0] ovf_cnt;
  logic       ovf_sticky;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  bit          done     = 1'b0;
  logic [7:0]  q [$];

  sigmag_packer_if #(.WORD_W(8)) bus ();

  sigmag_packer #(.WORD_W(8), .FIFO_DEPTH(4), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .sig_i      (sig_i),
    .mag_i      (mag_i),
    .clear      (clear),
    .m          (bus),
    .fifo_level (fifo_level),
    .ovf_cnt    (ovf_cnt),
    .ovf_sticky (ovf_sticky)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: registered outputs sampled on the falling edge; a visible
  // valid&&ready handshake retires the scoreboard head.
  always @(negedge clk) begin
    if (!done && !clear) begin
      chk("m_valid", 32'(bus.m_valid), 32'(q.size() != 0));
      chk("fifo_level", 32'(fifo_level), 32'(q.size()));
      if (q.size() != 0) chk("m_data", 32'(bus.m_data), 32'(q[0]));
      else               chk("m_data_empty", 32'(bus.m_data), 32'd0);
      if (bus.m_valid && bus.m_ready && q.size() != 0) void'(q.pop_front());
    end
  end

  task automatic sample(input logic [1:0] s);
    en = 1'b1;
    {sig_i, mag_i} = s;
    @(posedge clk); #1;
    en = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w, input bit kept, input bit rdy_last, input bit gaps);
    for (int k = 0; k < 4; k++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 3)) begin
          en = 1'b0;
          sig_i = 1'($urandom);
          mag_i = 1'($urandom);
          @(posedge clk); #1;
        end
      end
      en = 1'b1;
      {sig_i, mag_i} = w[2*k +: 2];
      if (k == 3 && rdy_last) bus.m_ready = 1'b1;
      @(posedge clk); #1;
    end
    en = 1'b0;
    if (kept) q.push_back(w);
  endtask

  task automatic drain();
    bus.m_ready = 1'b1;
    for (int i = 0; i < 40 && (q.size() != 0 || bus.m_valid); i++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
    chk("drain_valid", 32'(bus.m_valid), 32'd0);
  endtask

  initial begin
    bus.m_ready = 1'b0;
    #2;
    chk("rst_valid", 32'(bus.m_valid), 32'd0);
    chk("rst_data", 32'(bus.m_data), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    chk("rst_ovf", 32'(ovf_cnt), 32'd0);
    chk("rst_sticky", 32'(ovf_sticky), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Basic packing, sample 0 in the LSBs.
    bus.m_ready = 1'b1;
    send_word(8'h2D, 1'b1, 1'b0, 1'b0);
    chk("t1_valid", 32'(bus.m_valid), 32'd1);
    chk("t1_data", 32'(bus.m_data), 32'h2D);
    drain();

    // Overflow: the fifth word is dropped.
    bus.m_ready = 1'b0;
    send_word(8'h11, 1'b1, 1'b0, 1'b0);
    send_word(8'h22, 1'b1, 1'b0, 1'b0);
    send_word(8'h33, 1'b1, 1'b0, 1'b0);
    send_word(8'h44, 1'b1, 1'b0, 1'b0);
    send_word(8'h55, 1'b0, 1'b0, 1'b0);
    chk("t2_level", 32'(fifo_level), 32'd4);
    chk("t2_ovf", 32'(ovf_cnt), 32'd1);
    chk("t2_sticky", 32'(ovf_sticky), 32'd1);
    drain();

    // Full FIFO with a pop on the completing edge: no drop.
    bus.m_ready = 1'b0;
    send_word(8'hA1, 1'b1, 1'b0, 1'b0);
    send_word(8'hB2, 1'b1, 1'b0, 1'b0);
    send_word(8'hC3, 1'b1, 1'b0, 1'b0);
    send_word(8'hD4, 1'b1, 1'b0, 1'b0);
    chk("t3_full", 32'(fifo_level), 32'd4);
    send_word(8'hE5, 1'b1, 1'b1, 1'b0);
    chk("t3_level", 32'(fifo_level), 32'd4);
    chk("t3_ovf", 32'(ovf_cnt), 32'd1);
    drain();

    // Clear mid-word discards the partial word and the clear-cycle sample.
    bus.m_ready = 1'b0;
    sample(2'b10);
    sample(2'b01);
    clear = 1'b1;
    en = 1'b1;
    {sig_i, mag_i} = 2'b01;
    q.delete();
    @(posedge clk); #1;
    clear = 1'b0;
    en = 1'b0;
    chk("t4_ovf_clr", 32'(ovf_cnt), 32'd0);
    chk("t4_sticky_clr", 32'(ovf_sticky), 32'd0);
    send_word(8'hFF, 1'b1, 1'b0, 1'b0);
    chk("t4_data", 32'(bus.m_data), 32'hFF);
    chk("t4_level", 32'(fifo_level), 32'd1);
    chk("t4_ovf", 32'(ovf_cnt), 32'd0);
    drain();

    // Saturating drop counter, then async reset mid-word.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_word(8'(8'h61 + i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) send_word(8'h5A, 1'b0, 1'b0, 1'b0);
    chk("t5_ovf_sat", 32'(ovf_cnt), 32'd15);
    chk("t5_sticky", 32'(ovf_sticky), 32'd1);
    chk("t5_level", 32'(fifo_level), 32'd4);
    sample(2'b11);
    sample(2'b01);
    reset = 1'b1;
    q.delete();
    #2;
    chk("t5_rst_valid", 32'(bus.m_valid), 32'd0);
    chk("t5_rst_data", 32'(bus.m_data), 32'd0);
    chk("t5_rst_level", 32'(fifo_level), 32'd0);
    chk("t5_rst_ovf", 32'(ovf_cnt), 32'd0);
    chk("t5_rst_sticky", 32'(ovf_sticky), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    send_word(8'h2D, 1'b1, 1'b0, 1'b0);
    chk("t5_post_rst_data", 32'(bus.m_data), 32'h2D);
    drain();

    // Gapped strobes; data must hold while the sink stalls.
    bus.m_ready = 1'b0;
    send_word(8'h2D, 1'b1, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("t6_hold_data", 32'(bus.m_data), 32'h2D);
    chk("t6_hold_valid", 32'(bus.m_valid), 32'd1);
    drain();

    repeat (2) @(posedge clk);
    #1;
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
